debounce_tick_fsm: RTL and testbench



---
 rtl/debounce_tick_fsm_pkg.sv | 17 +
 rtl/debounce_tick_fsm_sync_2ff.sv | 24 ++
 rtl/debounce_tick_fsm.sv | 89 ++++++++
 tb/tb_debounce_tick_fsm.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/debounce_tick_fsm_pkg.sv
// debounce_tick_fsm_pkg: state encoding and width helper shared by the debouncer
package debounce_tick_fsm_pkg;

    typedef enum logic [1:0] {
        ZERO  = 2'b00,
        WAIT1 = 2'b01,
        ONE   = 2'b10,
        WAIT0 = 2'b11
    } state_t;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/debounce_tick_fsm_sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous pin, resets to 0
module sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/debounce_tick_fsm.sv
// debounce_tick_fsm: accepts a switch level change only after it holds for
// STABLE_TICKS timer ticks; registered level plus one-cycle rise/fall pulses.
module debounce_tick_fsm
    import debounce_tick_fsm_pkg::*;
#(
    parameter int STABLE_TICKS = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic sw_in,
    output logic db_level,
    output logic db_rise,
    output logic db_fall
);

    localparam int CW = clog2(STABLE_TICKS + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

    logic          sw_s;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    sync_2ff u_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .d      (sw_in),
        .q      (sw_s)
    );

    // A mismatch on sw_s aborts before the tick is looked at, so an aborting tick is never counted.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ZERO: if (sw_s) begin
                state_d = WAIT1;
                cnt_d   = '0;
            end
            WAIT1: if (!sw_s) begin
                state_d = ZERO;
                cnt_d   = '0;
            end else if (tick) begin
                state_d = (cnt_q == LAST) ? ONE : WAIT1;
                rise_d  = (cnt_q == LAST);
                cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
            end
            ONE: if (!sw_s) begin
                state_d = WAIT0;
                cnt_d   = '0;
            end
            WAIT0: if (sw_s) begin
                state_d = ONE;
                cnt_d   = '0;
            end else if (tick) begin
                state_d = (cnt_q == LAST) ? ZERO : WAIT0;
                fall_d  = (cnt_q == LAST);
                cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
            end
        endcase
        level_d = (state_d == ONE) || (state_d == WAIT0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ZERO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign db_level = level_q;
    assign db_rise  = rise_q;
    assign db_fall  = fall_q;

endmodule

// File: tb/tb_debounce_tick_fsm.sv
// tb_debounce_tick_fsm: per-cycle scoreboard against a behavioural model plus
// table-driven segments with hand-computed end-of-segment expectations.
module tb_debounce_tick_fsm;

    localparam int ST = 4;

    logic clk;
    logic reset_n;
    logic tick;
    logic sw_in;
    logic db_level;
    logic db_rise;
    logic db_fall;

    int total  = 0;
    int passes = 0;

    debounce_tick_fsm #(.STABLE_TICKS(ST)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick),
        .sw_in   (sw_in),
        .db_level(db_level),
        .db_rise (db_rise),
        .db_fall (db_fall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Behavioural reference: a pending change must see ST ticks after the cycle it is noticed.
    logic [2:0] exp_q[$];
    logic m_s1 = 1'b0, m_s2 = 1'b0, m_lvl = 1'b0, m_wait = 1'b0;
    int   m_n = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_s1   <= 1'b0;
            m_s2   <= 1'b0;
            m_lvl  <= 1'b0;
            m_wait <= 1'b0;
            m_n    <= 0;
            exp_q.delete();
            exp_q.push_back(3'b000);
        end else begin : step
            logic lvl, wt, r, f;
            int   n;
            lvl = m_lvl;
            wt  = m_wait;
            n   = m_n;
            r   = 1'b0;
            f   = 1'b0;
            if (!wt) begin
                if (m_s2 != lvl) begin
                    wt = 1'b1;
                    n  = 0;
                end
            end else if (m_s2 == lvl) begin
                wt = 1'b0;
            end else if (tick) begin
                n++;
                if (n == ST) begin
                    lvl = ~lvl;
                    r   = lvl;
                    f   = ~lvl;
                    wt  = 1'b0;
                end
            end
            m_lvl  <= lvl;
            m_wait <= wt;
            m_n    <= n;
            m_s2   <= m_s1;
            m_s1   <= sw_in;
            exp_q.push_back({lvl, r, f});
        end
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [2:0] e;
            e = exp_q.pop_front();
            check("cycle_outputs", int'({db_level, db_rise, db_fall}), int'(e));
        end
    end

    typedef struct {
        logic sw;
        int   cyc;
        int   per;
        int   ph;
        logic lvl;
        int   rise;
        int   fall;
    } seg_t;

    task automatic run_seg(input string nm, input seg_t s);
        int rises = 0, falls = 0;
        for (int i = 0; i < s.cyc; i++) begin
            sw_in = s.sw;
            tick  = ((i % s.per) == s.ph);
            @(negedge clk);
            rises += int'(db_rise);
            falls += int'(db_fall);
            check({nm, "_both"}, int'(db_rise & db_fall), 0);
        end
        check({nm, "_level"}, int'(db_level), int'(s.lvl));
        check({nm, "_rises"}, rises, s.rise);
        check({nm, "_falls"}, falls, s.fall);
    endtask

    task automatic mid_reset(input string nm);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 check({nm, "_immediate"}, int'({db_level, db_rise, db_fall}), 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    seg_t tbl[12];

    initial begin
        tbl[0]  = '{1'b0, 100, 10, 9, 1'b0, 0, 0};
        tbl[1]  = '{1'b1,  80, 10, 9, 1'b1, 1, 0};
        tbl[2]  = '{1'b0,  80, 10, 9, 1'b0, 0, 1};
        tbl[3]  = '{1'b1,  25, 10, 9, 1'b0, 0, 0};
        tbl[4]  = '{1'b0,   5, 10, 9, 1'b0, 0, 0};
        tbl[5]  = '{1'b1,  80, 10, 9, 1'b1, 1, 0};
        tbl[6]  = '{1'b0,  60,  1, 0, 1'b0, 0, 1};
        tbl[7]  = '{1'b1,   3,  1, 0, 1'b0, 0, 0};
        tbl[8]  = '{1'b0,  20,  1, 0, 1'b0, 0, 0};
        tbl[9]  = '{1'b1,  37, 10, 9, 1'b0, 0, 0};
        tbl[10] = '{1'b0,  20, 10, 2, 1'b0, 0, 0};
        tbl[11] = '{1'b1,  80, 10, 9, 1'b1, 1, 0};

        reset_n = 1'b0;
        sw_in   = 1'b0;
        tick    = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("reset_hold", int'({db_level, db_rise, db_fall}), 0);
        end
        reset_n = 1'b1;

        for (int k = 0; k < 12; k++) run_seg($sformatf("seg%0d", k), tbl[k]);

        // Reset in WAIT0 with db_level high: level must drop at once, no fall pulse afterwards.
        run_seg("wait0_pre", '{1'b0, 20, 10, 9, 1'b1, 0, 0});
        mid_reset("rst_wait0");
        run_seg("wait0_post", '{1'b0, 30, 10, 9, 1'b0, 0, 0});

        // Reset in WAIT1 after 3 ticks: a fresh 4 ticks are needed after release.
        run_seg("wait1_pre", '{1'b1, 35, 10, 9, 1'b0, 0, 0});
        mid_reset("rst_wait1");
        run_seg("wait1_post_a", '{1'b1, 39, 10, 9, 1'b0, 0, 0});
        run_seg("wait1_post_b", '{1'b1, 20, 10, 0, 1'b1, 1, 0});

        @(negedge clk);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
